register_window: RTL and testbench

//  Parametrised successor to the fixed 32-bit register: a DEPTH-word x WIDTH-bit shift window with

---
 rtl/register_pkg.sv | 15 +
 rtl/register_window_if.sv | 11 +
 rtl/register_cell.sv | 28 ++
 rtl/register_window.sv | 106 ++++++++++
 tb/tb_register_window.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_pkg.sv
// Shared constants and width helpers for register_window and the SHA-256 datapath.
package register_pkg;

  localparam int unsigned MODE_SLIDE = 0;
  localparam int unsigned MODE_FILL  = 1;

  // Ceiling log2, never less than 1 so that single-entry ranges still get a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'(1) << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/register_window_if.sv
// Valid/ready push channel into register_window.
interface register_window_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/register_cell.sv
// WIDTH-bit storage cell: async active-low reset, sync clear (priority), load enable.
module register_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clear)   q_d = '0;
    else if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/register_window.sv
// DEPTH x WIDTH shift window with push handshake, fill count and random read port.
// Optional snapshot bank enabled by REGISTER_WINDOW_SNAPSHOT_EN.
module register_window import register_pkg::*; #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned MODE  = MODE_SLIDE,
  localparam int unsigned IDX_W = clog2(DEPTH),
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  register_window_if.slave       push_if,
  input  logic                   clear,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [WIDTH-1:0]       rd_data,
  output logic [WIDTH*DEPTH-1:0] window_q,
  output logic [CNT_W-1:0]       count,
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
  input  logic                   snap,
  output logic [WIDTH*DEPTH-1:0] snap_q,
`endif
  output logic                   full
);

  localparam int unsigned RD_N = 32'(1) << IDX_W;

  logic             ready_c;
  logic             push;
  logic [WIDTH-1:0] word   [DEPTH];
  logic [WIDTH-1:0] word_d [DEPTH];
  logic [WIDTH-1:0] rd_tbl [RD_N];
  logic [CNT_W-1:0] count_d, count_q;
  logic             full_d, full_q;

  // Clear always wins; FILL mode additionally stalls once the window is full.
  assign ready_c          = ~clear & ((MODE == MODE_SLIDE) | ~full_q);
  assign push_if.in_ready = ready_c;
  assign push             = push_if.in_valid & ready_c;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if (g == 0) begin : g_head
      assign word_d[g] = push_if.in_data;
    end else begin : g_tail
      assign word_d[g] = word[g-1];
    end

    register_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .rst_n (reset),
      .clear (clear),
      .en    (push),
      .d     (word_d[g]),
      .q     (word[g])
    );

    assign window_q[g*WIDTH +: WIDTH] = word[g];
  end

  // Padded read table so out-of-range indices return zero.
  for (genvar g = 0; g < RD_N; g++) begin : g_rd
    if (g < DEPTH) begin : g_live
      assign rd_tbl[g] = word[g];
    end else begin : g_pad
      assign rd_tbl[g] = '0;
    end
  end

  assign rd_data = rd_tbl[rd_idx];

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (push && (count_q != CNT_W'(DEPTH)))
      count_d = count_q + CNT_W'(1);
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;

`ifdef REGISTER_WINDOW_SNAPSHOT_EN
  // Snapshot captures pre-push contents and ignores clear.
  for (genvar g = 0; g < DEPTH; g++) begin : g_snap
    register_cell #(.WIDTH(WIDTH)) u_snap (
      .clk   (clk),
      .rst_n (reset),
      .clear (1'b0),
      .en    (snap),
      .d     (word[g]),
      .q     (snap_q[g*WIDTH +: WIDTH])
    );
  end
`endif

endmodule

// File: tb/tb_register_window.sv
// Bench for register_window: SLIDE/FILL 16x32 plus a 5x8 SLIDE instance, against a queue model.
module tb_register_window;
  import register_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, in_valid;
  logic [31:0] in_data;
  logic [3:0]  rd_idx4;
  logic [2:0]  rd_idx3;

  register_window_if #(.WIDTH(32)) if0 ();
  register_window_if #(.WIDTH(32)) if1 ();
  register_window_if #(.WIDTH(8))  if2 ();

  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;
  assign if2.in_valid = in_valid;
  assign if2.in_data  = in_data[7:0];

  logic [31:0]  rd0, rd1;
  logic [7:0]   rd2;
  logic [511:0] w0, w1;
  logic [39:0]  w2;
  logic [4:0]   c0, c1;
  logic [2:0]   c2;
  logic         f0, f1, f2;

`ifdef REGISTER_WINDOW_SNAPSHOT_EN
  logic         snap;
  logic [511:0] snap_q;
  logic [31:0]  ms [16];
`endif

  register_window #(.WIDTH(32), .DEPTH(16), .MODE(MODE_SLIDE)) u0 (
    .clk(clk), .reset(reset), .push_if(if0), .clear(clear), .rd_idx(rd_idx4),
    .rd_data(rd0), .window_q(w0), .count(c0),
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    .snap(snap), .snap_q(snap_q),
`endif
    .full(f0));

  register_window #(.WIDTH(32), .DEPTH(16), .MODE(MODE_FILL)) u1 (
    .clk(clk), .reset(reset), .push_if(if1), .clear(clear), .rd_idx(rd_idx4),
    .rd_data(rd1), .window_q(w1), .count(c1),
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    .snap(1'b0), .snap_q(),
`endif
    .full(f1));

  register_window #(.WIDTH(8), .DEPTH(5), .MODE(MODE_SLIDE)) u2 (
    .clk(clk), .reset(reset), .push_if(if2), .clear(clear), .rd_idx(rd_idx3),
    .rd_data(rd2), .window_q(w2), .count(c2),
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    .snap(1'b0), .snap_q(),
`endif
    .full(f2));

  logic [511:0] win_a [3];
  logic [31:0]  rdd_a [3];
  logic [4:0]   cnt_a [3];
  logic         full_a [3];
  logic         rdy_a [3];

  assign win_a[0] = w0;   assign win_a[1] = w1;   assign win_a[2] = {472'b0, w2};
  assign rdd_a[0] = rd0;  assign rdd_a[1] = rd1;  assign rdd_a[2] = {24'b0, rd2};
  assign cnt_a[0] = c0;   assign cnt_a[1] = c1;   assign cnt_a[2] = {2'b0, c2};
  assign full_a[0] = f0;  assign full_a[1] = f1;  assign full_a[2] = f2;
  assign rdy_a[0] = if0.in_ready; assign rdy_a[1] = if1.in_ready; assign rdy_a[2] = if2.in_ready;

  // Reference: each window is a queue, newest at the front, bounded by its depth.
  logic [31:0] mq [3][$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int dep_of(input int k);
    return (k == 2) ? 5 : 16;
  endfunction

  function automatic int wd_of(input int k);
    return (k == 2) ? 8 : 32;
  endfunction

  function automatic logic [31:0] mask_of(input int k);
    return (k == 2) ? 32'h0000_00ff : 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] mword(input int k, input int i);
    if (i < mq[k].size()) return mq[k][i];
    return 32'h0;
  endfunction

  function automatic logic exp_ready(input int k);
    return !clear && ((k != 1) || (mq[k].size() < dep_of(k)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < 3; k++) mq[k].delete();
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    for (int i = 0; i < 16; i++) ms[i] = 32'h0;
`endif
  endtask

  task automatic model_step();
    if (!reset) begin
      reset_model();
      return;
    end
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    if (snap) for (int i = 0; i < 16; i++) ms[i] = mword(0, i);
`endif
    for (int k = 0; k < 3; k++) begin
      if (clear) mq[k].delete();
      else if (in_valid && exp_ready(k)) begin
        mq[k].push_front(in_data & mask_of(k));
        if (mq[k].size() > dep_of(k)) void'(mq[k].pop_back());
      end
    end
  endtask

  task automatic check_all();
    int idx;
    logic [31:0] exp_rd;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d count", k), 64'(cnt_a[k]), 64'(mq[k].size()));
      chk($sformatf("u%0d full", k), 64'(full_a[k]), 64'(mq[k].size() == dep_of(k)));
      chk($sformatf("u%0d in_ready", k), 64'(rdy_a[k]), 64'(exp_ready(k)));
      idx    = (k == 2) ? int'(rd_idx3) : int'(rd_idx4);
      exp_rd = (idx < dep_of(k)) ? mword(k, idx) : 32'h0;
      chk($sformatf("u%0d rd_data[%0d]", k, idx), 64'(rdd_a[k]), 64'(exp_rd));
      for (int i = 0; i < dep_of(k); i++)
        chk($sformatf("u%0d window[%0d]", k, i),
            64'((win_a[k] >> (i * wd_of(k))) & 512'(mask_of(k))), 64'(mword(k, i)));
    end
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    for (int i = 0; i < 16; i++)
      chk($sformatf("snap_q[%0d]", i), 64'(snap_q[i*32 +: 32]), 64'(ms[i]));
`endif
  endtask

  // Inputs are stable from posedge+1; compare on negedge, advance the model on posedge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_idx4 = '0; rd_idx3 = '0;
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    snap = 1'b0;
`endif
    reset_model();
    #3;
    check_all();
    repeat (2) step();
    reset = 1'b1;

    // Async reset in the middle of a push with five words held.
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 32'(i * 11); step();
    end
    chk("t1 count before reset", 64'(c0), 64'd5);
    in_data = 32'd77;
    #2 reset = 1'b0;
    reset_model();
    #1;
    chk("t1 count at reset", 64'(c0), 64'd0);
    chk("t1 full at reset", 64'(f0), 64'd0);
    chk("t1 window at reset", 64'(w0 != '0), 64'd0);
    check_all();
    step();
    reset = 1'b1; in_valid = 1'b0;
    step();

    // Fill 1..16.
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 32'(i); rd_idx4 = 4'($urandom); step();
    end
    in_valid = 1'b0; rd_idx4 = 4'd0; #1;
    chk("t2 count", 64'(c0), 64'd16);
    chk("t2 full", 64'(f0), 64'd1);
    chk("t2 rd0 slide", 64'(rd0), 64'd16);
    chk("t2 rd0 fill", 64'(rd1), 64'd16);
    rd_idx4 = 4'd15; #1;
    chk("t2 rd15 slide", 64'(rd0), 64'd1);
    chk("t2 rd15 fill", 64'(rd1), 64'd1);
    step();

    // Slide past full.
    in_valid = 1'b1; in_data = 32'd17; step();
    in_valid = 1'b0; rd_idx4 = 4'd0; #1;
    chk("t3 count", 64'(c0), 64'd16);
    chk("t3 rd0", 64'(rd0), 64'd17);
    chk("t3 fill frozen", 64'(rd1), 64'd16);
    rd_idx4 = 4'd15; #1;
    chk("t3 rd15", 64'(rd0), 64'd2);

    // FILL stops when full; clear reopens it.
    in_valid = 1'b1; in_data = 32'd99; rd_idx4 = 4'd0;
    repeat (3) step();
    chk("t4 ready blocked", 64'(if1.in_ready), 64'd0);
    chk("t4 rd0 frozen", 64'(rd1), 64'd16);
    clear = 1'b1; step();
    clear = 1'b0; #1;
    chk("t4 count cleared", 64'(c1), 64'd0);
    chk("t4 ready reopened", 64'(if1.in_ready), 64'd1);
    step();
    in_valid = 1'b0; #1;
    chk("t4 rd0 after push", 64'(rd1), 64'd99);
    chk("t4 count after push", 64'(c1), 64'd1);

    // Clear beats push.
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd55; #1;
    chk("t5 ready during clear", 64'(if0.in_ready), 64'd0);
    step();
    clear = 1'b0; in_valid = 1'b0; #1;
    chk("t5 count u0", 64'(c0), 64'd0);
    chk("t5 count u1", 64'(c1), 64'd0);
    chk("t5 count u2", 64'(c2), 64'd0);

`ifdef REGISTER_WINDOW_SNAPSHOT_EN
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i); step();
    end
    snap = 1'b1; in_data = 32'd4; step();
    snap = 1'b0; in_valid = 1'b0; rd_idx4 = 4'd0; #1;
    chk("t6 snap newest", 64'(snap_q[31:0]), 64'd3);
    chk("t6 window newest", 64'(rd0), 64'd4);
    clear = 1'b1; step();
    clear = 1'b0; #1;
    chk("t6 snap after clear", 64'(snap_q[31:0]), 64'd3);
    chk("t6 snap word1 after clear", 64'(snap_q[63:32]), 64'd2);
`endif

    // Randomised traffic with occasional clear and async reset.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      clear    = ($urandom_range(0, 19) == 0);
      in_data  = $urandom;
      rd_idx4  = 4'($urandom);
      rd_idx3  = 3'($urandom);
`ifdef REGISTER_WINDOW_SNAPSHOT_EN
      snap     = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        reset_model();
        #1 check_all();
        step();
        reset = 1'b1;
      end
      step();
    end
    in_valid = 1'b0; clear = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
